// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
//   Handshake and data bundle for serial_adder.
//   Signals:
//     start      request a new addition (sampled by the adder only when idle)
//     a, b, cin  operands and carry-in, captured on the accepting edge
//     busy       adder is shifting or presenting its result
//     done       one-cycle pulse, s/cout (and ovf) valid
//     s, cout    registered sum and carry-out
//     ovf        two's-complement overflow, present only with SERIAL_ADDER_OVF_EN
//   Modports: master drives requests (testbench / host), slave is the adder.
//   Optional feature macro: SERIAL_ADDER_OVF_EN
// -----------------------------------------------------------------------------
interface serial_adder_if #(
   parameter int N = 8
);
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [N-1:0] s;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;

   modport master (output start, a, b, cin, input busy, done, s, cout, ovf);
   modport slave  (input start, a, b, cin, output busy, done, s, cout, ovf);
`else
   modport master (output start, a, b, cin, input busy, done, s, cout);
   modport slave  (input start, a, b, cin, output busy, done, s, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial N-bit adder: one full-adder evaluation per clock, LSB first.
//   A start accepted in IDLE loads the operands; N SHIFT cycles follow, then a
//   single DONE cycle in which done pulses and the registered result is valid.
//   s/cout only change on entry to DONE or on reset, so the previous result
//   stays visible while the next addition is running.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset (priority over start)
//     bus    serial_adder_if.slave: start, a, b, cin in; busy, done, s, cout out
//   Parameter: N operand/result width, 2..32.
//   Optional feature macro: SERIAL_ADDER_OVF_EN adds bus.ovf, the signed
//   overflow flag registered alongside s.
// -----------------------------------------------------------------------------
module serial_adder #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_adder_if.slave  bus
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [N-1:0]    r_a;
   logic [N-1:0]    r_b;
   logic [N-1:0]    r_psum;
   logic [N-1:0]    r_s;
   logic            r_carry;
   logic            r_cout;
   logic [CW-1:0]   r_cnt;
`ifdef SERIAL_ADDER_OVF_EN
   logic            r_ovf;
`endif

   logic            w_load;
   logic            w_shift;
   logic            w_last;
   logic            w_busy;
   logic            w_done;
   logic            w_x;
   logic            w_y;
   logic            w_z;
   logic            w_sum;
   logic            w_carry;

   function automatic logic fa_sum(input logic x, input logic y, input logic z);
      return x ^ y ^ z;
   endfunction

   function automatic logic fa_carry(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   assign w_x     = r_a[0];
   assign w_y     = r_b[0];
   assign w_z     = r_carry;
   assign w_sum   = fa_sum(w_x, w_y, w_z);
   assign w_carry = fa_carry(w_x, w_y, w_z);

   // ---- control: state register -------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_last      = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_load      = 1'b1;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            w_busy  = 1'b1;
            w_shift = 1'b1;
            // counter value N-1 marks the MSB evaluation
            if (r_cnt == CW'(N - 1)) begin
               w_last      = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_busy      = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ---- datapath: operand shift, partial sum, result capture ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_psum  <= '0;
         r_s     <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else if (w_load) begin
         r_a     <= bus.a;
         r_b     <= bus.b;
         r_carry <= bus.cin;
         r_cnt   <= '0;
      end else if (w_shift) begin
         r_a     <= {1'b0, r_a[N-1:1]};
         r_b     <= {1'b0, r_b[N-1:1]};
         // sum bits enter at the MSB so after N shifts bit 0 sits at the LSB
         r_psum  <= {w_sum, r_psum[N-1:1]};
         r_carry <= w_carry;
         r_cnt   <= r_cnt + CW'(1);
         if (w_last) begin
            r_s    <= {w_sum, r_psum[N-1:1]};
            r_cout <= w_carry;
`ifdef SERIAL_ADDER_OVF_EN
            // carry flop holds the carry into bit N-1 during the last step
            r_ovf  <= w_z ^ w_carry;
`endif
         end
      end
   end

   assign bus.busy = w_busy;
   assign bus.done = w_done;
   assign bus.s    = r_s;
   assign bus.cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
   assign bus.ovf  = r_ovf;
`endif

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: N, 8, operand/result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: a  input  N  addend A; captured on accepted start.
REQ-006 Port: b  input  N  addend B; captured on accepted start.
REQ-007 Port: cin  input  1  carry-in; captured on accepted start.
REQ-008 Port: busy  output  1  high in SHIFT and DONE states.
REQ-009 Port: done  output  1  single-cycle pulse: result valid.
REQ-010 Port: s  output  N  registered sum.
REQ-011 Port: cout  output  1  registered carry-out.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 SHALL load operand shift registers with a, b, the carry flip-flop with cin, the bit counter with 0, and move to SHIFT.
REQ-014 IDLE with start=0 SHALL hold all registers.
REQ-015 In each SHIFT cycle, one full-adder evaluation SHALL occur: x = operand A LSB, y = operand B LSB, z = carry flip-flop; sum = odd parity of x,y,z; carry = majority of x,y,z.
REQ-016 In each SHIFT cycle, operand registers SHALL shift right by one, sum SHALL be shifted into the MSB of an internal partial-sum register, carry SHALL be written to the carry flip-flop, and the counter SHALL increment.
REQ-017 After exactly N SHIFT cycles (counter reaches N-1 and is processed), the FSM SHALL copy partial sum to s and final carry to cout, then enter DONE.
REQ-018 done SHALL be 1 for exactly the one cycle spent in DONE; DONE SHALL return to IDLE unconditionally.
REQ-019 Latency: start accepted at edge t0 -> done high in the cycle after edge tN; IDLE re-entered at edge tN+1.
REQ-020 Throughput: minimum start-to-start interval of N+2 cycles.
REQ-021 start asserted in SHIFT or DONE SHALL be ignored; no queuing.
REQ-022 s and cout SHALL change only on entry to DONE or on reset; they SHALL hold the last result through IDLE and the next SHIFT phase.
REQ-023 a, b, cin changes after the accepting edge SHALL have no effect on the current result.
REQ-024 Result SHALL equal (a + b + cin) mod 2^N, with cout = bit N of the full sum.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, s=0, cout=0, counter=0, carry=0, operand registers=0.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-027 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-028 Macro SERIAL_ADDER_OVF_EN: when defined, an extra output port ovf (1 bit) SHALL exist, registered with s, equal to the carry into bit N-1 XOR cout (two's-complement overflow), reset to 0.
REQ-029 When SERIAL_ADDER_OVF_EN is undefined, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (N=8)
REQ-030 a=0x5A, b=0x3C, cin=0, start pulse -> done after 9 cycles, s=0x96, cout=0.
REQ-031 a=0xFF, b=0x01, cin=0 -> s=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> s=0xFF, cout=1.
REQ-032 start held high for 20 cycles with a=0x01, b=0x01 -> done pulses at cycle 9 and cycle 19, each s=0x02; a/b changed mid-SHIFT do not alter the result.
REQ-033 rst_n driven low during the 4th SHIFT cycle -> next cycle busy=0, s=0x00, cout=0; no done pulse.
REQ-034 With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01 -> s=0x80, ovf=1; a=0x80, b=0x80 -> s=0x00, cout=1, ovf=1; a=0x10, b=0x20 -> ovf=0.
